temp_poll_master: RTL and testbench



---
 rtl/temp_poll_master_if.sv | 63 ++++++
 rtl/temp_poll_master.sv | 204 ++++++++++++++++++++
 tb/tb_temp_poll_master.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_poll_master_if.sv
// nasti_channel: NASTI-lite bundle between a single initiator and a slave.
//   AR/R carry full read address/data fields; the write channels carry only
//   handshake and response signals, enough for an initiator to tie them off.
//   Modports: master (initiator side), slave (target side).
interface nasti_channel #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1
);
    // read address channel
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_lock;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;
    logic [3:0]            ar_region;
    logic [USER_WIDTH-1:0] ar_user;
    logic                  ar_valid;
    logic                  ar_ready;

    // read data channel
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    // write channels, handshake only
    logic                  aw_valid;
    logic                  aw_ready;
    logic                  w_valid;
    logic                  w_ready;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;

    modport master (
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready,
        output aw_valid, w_valid, b_ready,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready,
        input  aw_valid, w_valid, b_ready,
        output aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/temp_poll_master.sv
// temp_poll_master: periodically reads one memory-mapped temperature word over
// NASTI-lite and drives an over-temperature alarm with hysteresis.
//   clk, rst        clock, asynchronous active-high reset
//   enable          polling enable
//   alarm_set/clr   alarm rises at value >= alarm_set, falls at value < alarm_clr
//   err_clr         pulse clearing the sticky error (and timeout flag)
//   temp_value      last good read data; temp_valid pulses when it updates
//   alarm, err      over-temperature alarm, sticky protocol/response error
//   nasti           master side of the bus; only AR/R are active
// Build option: define POLL_TIMEOUT_EN to add an R-wait timeout that raises
// err and forces alarm (fan-on fail-safe) when the slave never answers.
module temp_poll_master #(
    parameter int unsigned           ID_WIDTH    = 1,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           USER_WIDTH  = 1,
    parameter logic [ADDR_WIDTH-1:0] POLL_ADDR   = ADDR_WIDTH'(32'h4),
    parameter logic [ID_WIDTH-1:0]   POLL_ID     = '0,
    parameter int unsigned           POLL_PERIOD = 1024,
    parameter int unsigned           TIMEOUT     = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] alarm_set,
    input  logic [DATA_WIDTH-1:0] alarm_clr,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] temp_value,
    output logic                  temp_valid,
    output logic                  alarm,
    output logic                  err,
    nasti_channel.master          nasti
);

    localparam int unsigned CNT_W   = $clog2(POLL_PERIOD + 1);
    localparam logic [2:0]  AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] temp_value_d;
    logic                  temp_valid_d;
    logic                  alarm_d;
    logic                  err_d;
    logic                  resp_bad;

`ifdef POLL_TIMEOUT_EN
    localparam int unsigned RCNT_W = $clog2(TIMEOUT + 1);
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              timeout_q, timeout_d;
    logic              late;
`endif

    // Constant single-beat INCR read of the polled register
    assign nasti.ar_id     = POLL_ID;
    assign nasti.ar_addr   = POLL_ADDR;
    assign nasti.ar_len    = 8'd0;
    assign nasti.ar_size   = AR_SIZE;
    assign nasti.ar_burst  = 2'b01;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'd0;
    assign nasti.ar_prot   = 3'd0;
    assign nasti.ar_qos    = 4'd0;
    assign nasti.ar_region = 4'd0;
    assign nasti.ar_user   = '0;
    assign nasti.ar_valid  = (state_q == ADDR);
    assign nasti.r_ready   = (state_q == DATA);

    // Write channels tied off
    assign nasti.aw_valid  = 1'b0;
    assign nasti.w_valid   = 1'b0;
    assign nasti.b_ready   = 1'b1;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, nasti.aw_ready, nasti.w_ready, nasti.b_valid,
                             nasti.b_resp, nasti.r_user};

`ifdef POLL_TIMEOUT_EN
    // Timeout flag is kept for debug visibility only
    logic unused_timeout;
    assign unused_timeout = timeout_q;
    // Saturated R-wait counter marks a beat that arrives after the timeout
    assign late = (rcnt_q == RCNT_W'(TIMEOUT));
`else
    logic unused_timeout_param;
    assign unused_timeout_param = TIMEOUT[0];
`endif

    assign resp_bad = (nasti.r_resp != 2'b00) || (nasti.r_id != POLL_ID) || !nasti.r_last;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            temp_value <= '0;
            temp_valid <= 1'b0;
            alarm      <= 1'b0;
            err        <= 1'b0;
`ifdef POLL_TIMEOUT_EN
            rcnt_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            temp_value <= temp_value_d;
            temp_valid <= temp_valid_d;
            alarm      <= alarm_d;
            err        <= err_d;
`ifdef POLL_TIMEOUT_EN
            rcnt_q     <= rcnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Next-state and next-output logic; error sets are applied after err_clr so they win
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        temp_value_d = temp_value;
        temp_valid_d = 1'b0;
        alarm_d      = alarm;
        err_d        = err;
        if (err_clr) begin
            err_d = 1'b0;
        end
`ifdef POLL_TIMEOUT_EN
        rcnt_d    = rcnt_q;
        timeout_d = timeout_q;
        if (err_clr) begin
            timeout_d = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (nasti.ar_ready) begin
                    state_d = DATA;
`ifdef POLL_TIMEOUT_EN
                    rcnt_d  = '0;
`endif
                end
            end

            DATA: begin
                if (nasti.r_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(POLL_PERIOD - 1);
`ifdef POLL_TIMEOUT_EN
                    if (late) begin
                        // beat answering a timed-out read is dropped
                    end else
`endif
                    if (resp_bad) begin
                        err_d = 1'b1;
                    end else begin
                        temp_value_d = nasti.r_data;
                        temp_valid_d = 1'b1;
                        if (nasti.r_data >= alarm_set) begin
                            alarm_d = 1'b1;
                        end else if (nasti.r_data < alarm_clr) begin
                            alarm_d = 1'b0;
                        end
`ifdef POLL_TIMEOUT_EN
                        timeout_d = 1'b0;
`endif
                    end
                end
`ifdef POLL_TIMEOUT_EN
                else if (!late) begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                    if (rcnt_q == RCNT_W'(TIMEOUT - 1)) begin
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                        alarm_d   = 1'b1;
                    end
                end
`endif
            end

            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ADDR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_temp_poll_master.sv
// tb_temp_poll_master: self-checking bench for temp_poll_master acting as the
// NASTI slave; good reads are scoreboarded and checked when temp_valid pulses.
module tb_temp_poll_master;

    localparam int unsigned PERIOD = 8;
    localparam int unsigned TOUT   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] alarm_set = 32'd60;
    logic [31:0] alarm_clr = 32'd50;
    logic [31:0] temp_value;
    logic        temp_valid;
    logic        alarm;
    logic        err;

    nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1)) nif ();

    temp_poll_master #(
        .ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1),
        .POLL_ADDR(32'h4), .POLL_ID(1'b0), .POLL_PERIOD(PERIOD), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .alarm_set(alarm_set), .alarm_clr(alarm_clr), .err_clr(err_clr),
        .temp_value(temp_value), .temp_valid(temp_valid),
        .alarm(alarm), .err(err), .nasti(nif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        alarm;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        id;
        logic        last;
        logic        clr_with;
        logic        good;
        logic        exp_alarm;
        logic        exp_err;
    } vec_t;

    localparam int NV = 13;
    vec_t vec[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every temp_valid pulse must match the oldest expected good read
    logic prev_tv = 1'b0;
    always @(negedge clk) begin : monitor
        sb_t e;
        if (!rst && temp_valid === 1'b1) begin
            check("tv_pulse", 64'(prev_tv), 64'd0);
            if (sbq.size() == 0) begin
                check("unexpected_temp_valid", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_temp", 64'(temp_value), 64'(e.data));
                check("sb_alarm", 64'(alarm), 64'(e.alarm));
            end
        end
        prev_tv = temp_valid;
    end

    // One read transaction as the slave; returns at the negedge after the R handshake
    task automatic do_poll(input logic [31:0] d, input logic [1:0] resp, input logic id,
                           input logic last, input int ar_delay, input int drop_at,
                           input logic clr_with);
        int   n;
        logic held;
        n = 0;
        while (nif.ar_valid !== 1'b1 && n < 4 * PERIOD + 50) begin
            @(negedge clk);
            n++;
        end
        check("ar_valid_seen", 64'(nif.ar_valid), 64'd1);
        if (nif.ar_valid !== 1'b1) return;
        held = 1'b1;
        for (int i = 0; i < ar_delay; i++) begin
            if (i == drop_at) enable = 1'b0;
            @(negedge clk);
            if (nif.ar_valid !== 1'b1) held = 1'b0;
        end
        if (ar_delay > 0) check("ar_hold", 64'(held), 64'd1);
        nif.ar_ready = 1'b1;
        @(negedge clk);
        nif.ar_ready = 1'b0;
        check("r_ready_in_data", 64'(nif.r_ready), 64'd1);
        check("ar_drop", 64'(nif.ar_valid), 64'd0);
        @(negedge clk);
        nif.r_valid = 1'b1;
        nif.r_data  = d;
        nif.r_resp  = resp;
        nif.r_id    = id;
        nif.r_last  = last;
        err_clr     = clr_with;
        @(negedge clk);
        nif.r_valid = 1'b0;
        err_clr     = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] exp_temp;
        int          steps;
        int          seen;
        sb_t         e;

        //            data    resp   id    last  clr   good  alarm err
        vec[0]  = '{32'd42, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[1]  = '{32'd55, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[2]  = '{32'd60, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[3]  = '{32'd55, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[4]  = '{32'd49, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{32'd52, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[6]  = '{32'd99, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[7]  = '{32'd80, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[8]  = '{32'd10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[9]  = '{32'd10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[10] = '{32'd50, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[11] = '{32'd10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[12] = '{32'd20, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        nif.ar_ready = 1'b0; nif.r_valid = 1'b0; nif.r_data = '0; nif.r_resp = 2'b00;
        nif.r_id = 1'b0; nif.r_last = 1'b0; nif.r_user = 1'b0;
        nif.aw_ready = 1'b0; nif.w_ready = 1'b0; nif.b_valid = 1'b0; nif.b_resp = 2'b00;
        exp_temp = 32'd0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ar_valid", 64'(nif.ar_valid), 64'd0);
        check("rst_r_ready", 64'(nif.r_ready), 64'd0);
        check("rst_temp", 64'(temp_value), 64'd0);
        check("rst_tv", 64'(temp_valid), 64'd0);
        check("rst_alarm", 64'(alarm), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("aw_valid", 64'(nif.aw_valid), 64'd0);
        check("w_valid", 64'(nif.w_valid), 64'd0);
        check("b_ready", 64'(nif.b_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_ar", 64'(nif.ar_valid), 64'd0);
        enable = 1'b1;
        @(negedge clk);
        check("ar_after_enable", 64'(nif.ar_valid), 64'd1);
        check("ar_addr", 64'(nif.ar_addr), 64'h4);
        check("ar_len", 64'(nif.ar_len), 64'd0);
        check("ar_size", 64'(nif.ar_size), 64'd2);
        check("ar_burst", 64'(nif.ar_burst), 64'd1);
        check("ar_id", 64'(nif.ar_id), 64'd0);
        check("ar_misc", 64'({nif.ar_lock, nif.ar_cache, nif.ar_prot, nif.ar_qos,
                              nif.ar_region, nif.ar_user}), 64'd0);

        // table: hysteresis, error responses, err_clr, poll period
        for (int i = 0; i < NV; i++) begin
            if (vec[i].good) begin
                e.data  = vec[i].data;
                e.alarm = vec[i].exp_alarm;
                sbq.push_back(e);
                exp_temp = vec[i].data;
            end
            do_poll(vec[i].data, vec[i].resp, vec[i].id, vec[i].last, 0, -1, vec[i].clr_with);
            check("tv_now", 64'(temp_valid), 64'(vec[i].good));
            check("err", 64'(err), 64'(vec[i].exp_err));
            check("temp_hold", 64'(temp_value), 64'(exp_temp));
            check("alarm", 64'(alarm), 64'(vec[i].exp_alarm));
            steps = 0;
            if (vec[i].exp_err) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                steps = 1;
                check("err_clr", 64'(err), 64'd0);
            end
            while (nif.ar_valid !== 1'b1 && steps < int'(PERIOD) + 20) begin
                @(negedge clk);
                steps++;
            end
            check("period", 64'(steps), 64'(PERIOD));
        end

        // ar_ready stalled, enable dropped mid-ADDR: read completes, then no more polls
        e.data = 32'd33; e.alarm = 1'b0; sbq.push_back(e); exp_temp = 32'd33;
        do_poll(32'd33, 2'b00, 1'b0, 1'b1, 10, 3, 1'b0);
        check("drop_temp", 64'(temp_value), 64'd33);
        seen = 0;
        for (int i = 0; i < 3 * int'(PERIOD); i++) begin
            @(negedge clk);
            if (nif.ar_valid === 1'b1) seen++;
        end
        check("no_ar_after_disable", 64'(seen), 64'd0);
        check("alarm_retained", 64'(alarm), 64'd0);

        // reset in DATA with r_valid pending
        enable = 1'b1;
        e.data = 32'd80; e.alarm = 1'b1; sbq.push_back(e);
        do_poll(32'd80, 2'b00, 1'b0, 1'b1, 0, -1, 1'b0);
        do_poll(32'd1, 2'b10, 1'b0, 1'b1, 0, -1, 1'b0);
        check("pre_rst_err", 64'(err), 64'd1);
        check("pre_rst_alarm", 64'(alarm), 64'd1);
        steps = 0;
        while (nif.ar_valid !== 1'b1 && steps < int'(PERIOD) + 20) begin
            @(negedge clk);
            steps++;
        end
        check("pre_rst_ar", 64'(nif.ar_valid), 64'd1);
        nif.ar_ready = 1'b1;
        @(negedge clk);
        nif.ar_ready = 1'b0;
        @(negedge clk);
        nif.r_valid = 1'b1; nif.r_data = 32'd5; nif.r_resp = 2'b00; nif.r_id = 1'b0; nif.r_last = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_r_ready", 64'(nif.r_ready), 64'd0);
        check("arst_ar_valid", 64'(nif.ar_valid), 64'd0);
        check("arst_temp", 64'(temp_value), 64'd0);
        check("arst_alarm", 64'(alarm), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_tv", 64'(temp_valid), 64'd0);
        @(negedge clk);
        nif.r_valid = 1'b0;
        rst = 1'b0;
        e.data = 32'd42; e.alarm = 1'b0; sbq.push_back(e);
        do_poll(32'd42, 2'b00, 1'b0, 1'b1, 0, -1, 1'b0);
        check("restart_temp", 64'(temp_value), 64'd42);

`ifdef POLL_TIMEOUT_EN
        // R withheld: timeout after TOUT cycles, late beat dropped, next good read clears alarm
        begin
            int   first;
            logic alarm_at;
            steps = 0;
            while (nif.ar_valid !== 1'b1 && steps < int'(PERIOD) + 20) begin
                @(negedge clk);
                steps++;
            end
            check("to_ar", 64'(nif.ar_valid), 64'd1);
            nif.ar_ready = 1'b1;
            @(negedge clk);
            nif.ar_ready = 1'b0;
            first = -1;
            alarm_at = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (err === 1'b1 && first < 0) begin
                    first = k;
                    alarm_at = alarm;
                end
            end
            check("timeout_cycle", 64'(first), 64'(TOUT));
            check("timeout_alarm", 64'(alarm_at), 64'd1);
            check("timeout_r_ready", 64'(nif.r_ready), 64'd1);
            nif.r_valid = 1'b1; nif.r_data = 32'd30; nif.r_resp = 2'b00; nif.r_id = 1'b0; nif.r_last = 1'b1;
            @(negedge clk);
            nif.r_valid = 1'b0;
            check("late_temp", 64'(temp_value), 64'd42);
            check("late_alarm", 64'(alarm), 64'd1);
            e.data = 32'd30; e.alarm = 1'b0; sbq.push_back(e);
            do_poll(32'd30, 2'b00, 1'b0, 1'b1, 0, -1, 1'b0);
            check("after_to_alarm", 64'(alarm), 64'd0);
            check("after_to_err", 64'(err), 64'd1);
        end
`endif

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
